// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit: CSR addresses,
// access opcodes, mstatus bit positions, WARL write masks and interrupt codes.
// Masks are kept 64 bits wide and cast down to XLEN at the point of use.
package csr_trap_unit_pkg;

    // Implemented CSR addresses
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    // CSR access opcode; READ performs no write at all
    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    // mstatus bit positions
    localparam int MST_MIE    = 3;
    localparam int MST_MPIE   = 7;
    localparam int MST_MPP_LO = 11;
    localparam int MST_MPP_HI = 12;

    // WARL writable-bit masks
    localparam logic [63:0] MSTATUS_WMASK       = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MIE_WMASK           = 64'h0000_0000_0000_0888;
    localparam logic [63:0] MCOUNTINHIBIT_WMASK = 64'h0000_0000_0000_0005;

    // mcountinhibit bit positions
    localparam int CNTINH_CY = 0;
    localparam int CNTINH_IR = 2;

    // Machine interrupt cause codes (also the mip/mie bit positions)
    localparam int IRQ_M_SW    = 3;
    localparam int IRQ_M_TIMER = 7;
    localparam int IRQ_M_EXT   = 11;

    // RW always writes; RS/RC only write when the source operand is non-zero
    function automatic logic is_write_attempt(input csr_op_t op, input logic wdata_nz);
        return (op == CSR_OP_RW) || (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && wdata_nz);
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit event counter with inhibit, increment enable and per-half write.
// Latency: write or increment visible the cycle after the enabling edge.
// Backpressure: none; a half write in a cycle takes precedence over the increment.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset (count -> 0)
//   inhibit_i    freeze counting
//   inc_i        count one event this cycle
//   wr_lo_i      replace bits [31:0] with wdata_i[31:0]
//   wr_hi_i      replace bits [63:32] with wdata_i[63:32]
//   wdata_i      write data for both halves
//   count_o      current count
module csr_counter64
    import csr_trap_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inhibit_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            // Any software write suppresses this cycle's increment so the
            // written value is read back exactly.
            if (wr_lo_i) cnt_d[31:0]  = wdata_i[31:0];
            if (wr_hi_i) cnt_d[63:32] = wdata_i[63:32];
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + 64'd1;  // natural wrap 2^64-1 -> 0
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with RMW access, WARL masking, counters, trap/mret sequencing and irq pending.
// Latency: reads and illegal flag combinational; CSR/trap/mret state next edge; irq_pending_o 1 cycle after mip.
// Backpressure: none; every access completes in its cycle; same-cycle priority trap > mret > CSR write.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   csr_v_i/op/adr/wdata       CSR access from execute; csr_rdata_o old value, csr_illegal_o fault
//   instret_i                  retire strobe for minstret
//   trap_v_i/cause/pc/tval     trap entry from commit; trap_target_o vector for trap_cause_i
//   mret_i                     mret commit; mepc_o return target
//   irq_sw/timer/ext_i         MSIP/MTIP/MEIP sources; irq_pending_o enabled interrupt pending
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MISA_RESET  = XLEN'(32'h4000_0100),
    parameter bit              VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_v_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_adr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            instret_i,
    input  logic            trap_v_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] trap_target_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam bit IS64 = (XLEN == 64);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            mst_mie_q,   mst_mie_d;
    logic            mst_mpie_q,  mst_mpie_d;
    logic [XLEN-1:0] mie_q,       mie_d;
    logic [XLEN-1:0] mtvec_q,     mtvec_d;
    logic [XLEN-1:0] mscratch_q,  mscratch_d;
    logic [XLEN-1:0] mepc_q,      mepc_d;
    logic [XLEN-1:0] mcause_q,    mcause_d;
    logic [XLEN-1:0] mtval_q,     mtval_d;
    logic [XLEN-1:0] mip_q,       mip_d;
    logic [XLEN-1:0] cntinh_q,    cntinh_d;
    logic            irq_pend_q,  irq_pend_d;

    logic [63:0]     mcycle_cnt;
    logic [63:0]     minstret_cnt;

    // ------------------------------------------------------------------
    // Address decode (one-hot)
    // ------------------------------------------------------------------
    csr_op_t op;
    assign op = csr_op_t'(csr_op_i);

    logic sel_mstatus, sel_misa, sel_mie, sel_mtvec, sel_cntinh, sel_mscratch;
    logic sel_mepc, sel_mcause, sel_mtval, sel_mip;
    logic sel_mcycle, sel_minstret, sel_mcycleh, sel_minstreth;
    logic sel_mvendorid, sel_marchid, sel_mimpid, sel_mhartid;
    logic implemented;

    assign sel_mstatus   = (csr_adr_i == CSR_MSTATUS);
    assign sel_misa      = (csr_adr_i == CSR_MISA);
    assign sel_mie       = (csr_adr_i == CSR_MIE);
    assign sel_mtvec     = (csr_adr_i == CSR_MTVEC);
    assign sel_cntinh    = (csr_adr_i == CSR_MCOUNTINHIBIT);
    assign sel_mscratch  = (csr_adr_i == CSR_MSCRATCH);
    assign sel_mepc      = (csr_adr_i == CSR_MEPC);
    assign sel_mcause    = (csr_adr_i == CSR_MCAUSE);
    assign sel_mtval     = (csr_adr_i == CSR_MTVAL);
    assign sel_mip       = (csr_adr_i == CSR_MIP);
    assign sel_mcycle    = (csr_adr_i == CSR_MCYCLE);
    assign sel_minstret  = (csr_adr_i == CSR_MINSTRET);
    // High-half aliases only exist when a counter does not fit in one register
    assign sel_mcycleh   = !IS64 && (csr_adr_i == CSR_MCYCLEH);
    assign sel_minstreth = !IS64 && (csr_adr_i == CSR_MINSTRETH);
    assign sel_mvendorid = (csr_adr_i == CSR_MVENDORID);
    assign sel_marchid   = (csr_adr_i == CSR_MARCHID);
    assign sel_mimpid    = (csr_adr_i == CSR_MIMPID);
    assign sel_mhartid   = (csr_adr_i == CSR_MHARTID);

    assign implemented = sel_mstatus | sel_misa | sel_mie | sel_mtvec | sel_cntinh
                       | sel_mscratch | sel_mepc | sel_mcause | sel_mtval | sel_mip
                       | sel_mcycle | sel_minstret | sel_mcycleh | sel_minstreth
                       | sel_mvendorid | sel_marchid | sel_mimpid | sel_mhartid;

    // ------------------------------------------------------------------
    // Read path: AND-OR mux over the one-hot selects
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] rd_mux;

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MST_MPP_HI:MST_MPP_LO] = 2'b11;  // machine-only hart: MPP hardwired
        mstatus_rd[MST_MPIE] = mst_mpie_q;
        mstatus_rd[MST_MIE]  = mst_mie_q;
    end

    always_comb begin
        rd_mux = '0;
        rd_mux = rd_mux | ({XLEN{sel_mstatus}}   & mstatus_rd);
        rd_mux = rd_mux | ({XLEN{sel_misa}}      & MISA_RESET);
        rd_mux = rd_mux | ({XLEN{sel_mie}}       & mie_q);
        rd_mux = rd_mux | ({XLEN{sel_mtvec}}     & mtvec_q);
        rd_mux = rd_mux | ({XLEN{sel_cntinh}}    & cntinh_q);
        rd_mux = rd_mux | ({XLEN{sel_mscratch}}  & mscratch_q);
        rd_mux = rd_mux | ({XLEN{sel_mepc}}      & mepc_q);
        rd_mux = rd_mux | ({XLEN{sel_mcause}}    & mcause_q);
        rd_mux = rd_mux | ({XLEN{sel_mtval}}     & mtval_q);
        rd_mux = rd_mux | ({XLEN{sel_mip}}       & mip_q);
        rd_mux = rd_mux | ({XLEN{sel_mcycle}}    & mcycle_cnt[XLEN-1:0]);
        rd_mux = rd_mux | ({XLEN{sel_minstret}}  & minstret_cnt[XLEN-1:0]);
        rd_mux = rd_mux | ({XLEN{sel_mcycleh}}   & XLEN'(mcycle_cnt[63:32]));
        rd_mux = rd_mux | ({XLEN{sel_minstreth}} & XLEN'(minstret_cnt[63:32]));
        rd_mux = rd_mux | ({XLEN{sel_mhartid}}   & HART_ID);
        // mvendorid/marchid/mimpid are implemented as zero
    end

    // ------------------------------------------------------------------
    // Access legality and write value
    // ------------------------------------------------------------------
    logic            write_try;
    logic            illegal_raw;
    logic            csr_we;
    logic [XLEN-1:0] wval;

    assign write_try   = is_write_attempt(op, |csr_wdata_i);
    // adr[11:10]==2'b11 is the read-only CSR space
    assign illegal_raw = !implemented || (write_try && (csr_adr_i[11:10] == 2'b11));

    assign csr_illegal_o = csr_v_i && illegal_raw;
    assign csr_rdata_o   = csr_illegal_o ? '0 : rd_mux;

    // Trap and mret own the cycle: a concurrent CSR write is dropped
    assign csr_we = csr_v_i && write_try && !illegal_raw && !trap_v_i && !mret_i;

    always_comb begin
        unique case (op)
            CSR_OP_RW: wval = csr_wdata_i;
            CSR_OP_RS: wval = rd_mux | csr_wdata_i;
            CSR_OP_RC: wval = rd_mux & ~csr_wdata_i;
            default:   wval = rd_mux;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        cntinh_d   = cntinh_q;

        // mip is a plain one-cycle sample of the interrupt lines
        mip_d              = '0;
        mip_d[IRQ_M_SW]    = irq_sw_i;
        mip_d[IRQ_M_TIMER] = irq_timer_i;
        mip_d[IRQ_M_EXT]   = irq_ext_i;

        irq_pend_d = mst_mie_q && |(mip_q & mie_q);

        if (trap_v_i) begin
            mepc_d     = trap_pc_i & ~XLEN'(3);
            mcause_d   = trap_cause_i;
            mtval_d    = trap_tval_i;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret_i) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_we) begin
            if (sel_mstatus) begin
                mst_mie_d  = wval[MST_MIE];
                mst_mpie_d = wval[MST_MPIE];
            end
            if (sel_mie)      mie_d      = wval & XLEN'(MIE_WMASK);
            if (sel_mtvec)    mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0] & VECTORED_EN};
            if (sel_cntinh)   cntinh_d   = wval & XLEN'(MCOUNTINHIBIT_WMASK);
            if (sel_mscratch) mscratch_d = wval;
            if (sel_mepc)     mepc_d     = wval & ~XLEN'(3);
            if (sel_mcause)   mcause_d   = wval;
            if (sel_mtval)    mtval_d    = wval;
            // misa and mip writes are accepted and ignored
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            cntinh_q   <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            cntinh_q   <= cntinh_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [63:0] cnt_wdata;
    logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

    // On RV32 each half has its own address; on RV64 the low address covers both
    assign cnt_wdata = IS64 ? 64'(wval) : {2{wval[31:0]}};
    assign cyc_wr_lo = csr_we && sel_mcycle;
    assign cyc_wr_hi = csr_we && (sel_mcycleh || (IS64 && sel_mcycle));
    assign ins_wr_lo = csr_we && sel_minstret;
    assign ins_wr_hi = csr_we && (sel_minstreth || (IS64 && sel_minstret));

    csr_counter64 u_mcycle (
        .clk       (clk),
        .reset     (reset),
        .inhibit_i (cntinh_q[CNTINH_CY]),
        .inc_i     (1'b1),
        .wr_lo_i   (cyc_wr_lo),
        .wr_hi_i   (cyc_wr_hi),
        .wdata_i   (cnt_wdata),
        .count_o   (mcycle_cnt)
    );

    csr_counter64 u_minstret (
        .clk       (clk),
        .reset     (reset),
        .inhibit_i (cntinh_q[CNTINH_IR]),
        .inc_i     (instret_i),
        .wr_lo_i   (ins_wr_lo),
        .wr_hi_i   (ins_wr_hi),
        .wdata_i   (cnt_wdata),
        .count_o   (minstret_cnt)
    );

    // ------------------------------------------------------------------
    // Trap vector, mret target, interrupt pending
    // ------------------------------------------------------------------
    always_comb begin
        trap_target_o = {mtvec_q[XLEN-1:2], 2'b00};
        // Vectored mode only offsets interrupts; exceptions go to the base
        if (mtvec_q[0] && trap_cause_i[XLEN-1]) begin
            trap_target_o = trap_target_o + XLEN'({trap_cause_i[4:0], 2'b00});
        end
    end

    assign mepc_o        = mepc_q;
    assign irq_pending_o = irq_pend_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Testbench for csr_trap_unit (XLEN=32): directed stimulus, expected values
// pushed to a scoreboard queue as stimulus is driven and compared when the
// corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_csr_trap_unit;
    import csr_trap_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_v_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_adr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        instret_i;
    logic        trap_v_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_tval_i;
    logic        mret_i;
    logic        irq_sw_i, irq_timer_i, irq_ext_i;
    logic        irq_pending_o;
    logic [31:0] trap_target_o;
    logic [31:0] mepc_o;

    csr_trap_unit dut (
        .clk           (clk),
        .reset         (reset),
        .csr_v_i       (csr_v_i),
        .csr_op_i      (csr_op_i),
        .csr_adr_i     (csr_adr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_illegal_o (csr_illegal_o),
        .instret_i     (instret_i),
        .trap_v_i      (trap_v_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .trap_tval_i   (trap_tval_i),
        .mret_i        (mret_i),
        .irq_sw_i      (irq_sw_i),
        .irq_timer_i   (irq_timer_i),
        .irq_ext_i     (irq_ext_i),
        .irq_pending_o (irq_pending_o),
        .trap_target_o (trap_target_o),
        .mepc_o        (mepc_o)
    );

    always #10 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_cmp(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.exp);
        end
    endtask

    // Advance one clock; pulse-type inputs are dropped after the edge
    task automatic step();
        @(posedge clk);
        #1;
        csr_v_i   = 1'b0;
        trap_v_i  = 1'b0;
        mret_i    = 1'b0;
        instret_i = 1'b0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] adr, input logic [31:0] wd);
        csr_v_i     = 1'b1;
        csr_op_i    = op;
        csr_adr_i   = adr;
        csr_wdata_i = wd;
        #1;
    endtask

    // Combinational read of one CSR, no clock edge consumed
    task automatic expect_rd(input logic [11:0] adr, input string tag, input logic [31:0] exp);
        drive(2'b00, adr, 32'h0);
        sb_push(tag, exp);
        sb_pop_cmp(csr_rdata_o);
        csr_v_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        csr_v_i = 0; csr_op_i = 0; csr_adr_i = 0; csr_wdata_i = 0;
        instret_i = 0; trap_v_i = 0; trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0;
        mret_i = 0; irq_sw_i = 0; irq_timer_i = 0; irq_ext_i = 0;
        #1;

        // Reset state
        sb_push("rst_irq_pending", 32'h0); sb_pop_cmp(32'(irq_pending_o));
        expect_rd(CSR_MSTATUS, "rst_mstatus", 32'h0000_1800);
        expect_rd(CSR_MISA,    "rst_misa",    32'h4000_0100);
        expect_rd(CSR_MTVEC,   "rst_mtvec",   32'h0);
        expect_rd(CSR_MCYCLE,  "rst_mcycle",  32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // RS / RC read-modify-write on mstatus (compare writable bits of old value)
        drive(2'b10, CSR_MSTATUS, 32'h88);
        sb_push("mst_rs_old", 32'h00); sb_pop_cmp(csr_rdata_o & 32'h88);
        step();
        drive(2'b11, CSR_MSTATUS, 32'h08);
        sb_push("mst_rc_old", 32'h88); sb_pop_cmp(csr_rdata_o & 32'h88);
        step();
        expect_rd(CSR_MSTATUS, "mst_final", 32'h0000_1880);

        // Read-only space and unimplemented addresses
        drive(2'b01, CSR_MVENDORID, 32'h5);
        sb_push("mvendor_rw_illegal", 32'h1); sb_pop_cmp(32'(csr_illegal_o));
        sb_push("mvendor_rw_rdata",   32'h0); sb_pop_cmp(csr_rdata_o);
        step();
        drive(2'b10, CSR_MVENDORID, 32'h0);
        sb_push("mvendor_rs0_legal", 32'h0); sb_pop_cmp(32'(csr_illegal_o));
        step();
        expect_rd(CSR_MVENDORID, "mvendor_val", 32'h0);
        drive(2'b00, 12'h7C0, 32'h0);
        sb_push("unimpl_illegal", 32'h1); sb_pop_cmp(32'(csr_illegal_o));
        step();
        drive(2'b01, CSR_MISA, 32'hFFFF_FFFF);
        sb_push("misa_wr_legal", 32'h0); sb_pop_cmp(32'(csr_illegal_o));
        step();
        expect_rd(CSR_MISA, "misa_unchanged", 32'h4000_0100);

        // mtvec WARL, vectored trap entry, mret
        drive(2'b01, CSR_MTVEC, 32'h0000_1003);
        step();
        expect_rd(CSR_MTVEC, "mtvec_warl", 32'h0000_1001);
        drive(2'b10, CSR_MSTATUS, 32'h08);
        step();
        trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h204; trap_tval_i = 32'h55; trap_v_i = 1'b1;
        #1;
        sb_push("trap_target_irq", 32'h0000_101C); sb_pop_cmp(trap_target_o);
        step();
        sb_push("mepc_o_trap", 32'h204); sb_pop_cmp(mepc_o);
        expect_rd(CSR_MCAUSE,  "mcause_trap",  32'h8000_0007);
        expect_rd(CSR_MTVAL,   "mtval_trap",   32'h55);
        expect_rd(CSR_MSTATUS, "mst_trap",     32'h0000_1880);
        trap_cause_i = 32'h2;
        #1;
        sb_push("trap_target_exc", 32'h0000_1000); sb_pop_cmp(trap_target_o);
        mret_i = 1'b1;
        step();
        expect_rd(CSR_MSTATUS, "mst_mret", 32'h0000_1888);
        drive(2'b01, CSR_MEPC, 32'h0000_0303);
        step();
        sb_push("mepc_warl", 32'h300); sb_pop_cmp(mepc_o);

        // Trap beats mret beats CSR write in the same cycle
        drive(2'b01, CSR_MSCRATCH, 32'hAA);
        trap_v_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'hB; trap_pc_i = 32'h402;
        #1;
        sb_push("prio_rdata_old", 32'h0); sb_pop_cmp(csr_rdata_o);
        step();
        expect_rd(CSR_MSCRATCH, "prio_mscratch", 32'h0);
        expect_rd(CSR_MEPC,     "prio_mepc",     32'h400);
        expect_rd(CSR_MSTATUS,  "prio_mstatus",  32'h0000_1880);

        // mcycle wrap through both halves, then inhibit
        drive(2'b01, CSR_MCYCLE, 32'hFFFF_FFFF);
        step();
        drive(2'b01, CSR_MCYCLEH, 32'hFFFF_FFFF);
        step();
        expect_rd(CSR_MCYCLE,  "cyc_lo_max", 32'hFFFF_FFFF);
        expect_rd(CSR_MCYCLEH, "cyc_hi_max", 32'hFFFF_FFFF);
        step();
        expect_rd(CSR_MCYCLE,  "cyc_lo_wrap", 32'h0);
        expect_rd(CSR_MCYCLEH, "cyc_hi_wrap", 32'h0);
        drive(2'b01, CSR_MCOUNTINHIBIT, 32'h1);
        step();
        repeat (3) step();
        expect_rd(CSR_MCYCLE,        "cyc_frozen", 32'h1);
        expect_rd(CSR_MCOUNTINHIBIT, "cntinh_val", 32'h1);

        // minstret counts retire strobes; inhibit bit 2 freezes it and releases mcycle
        for (int i = 0; i < 3; i++) begin
            instret_i = 1'b1;
            step();
            step();
        end
        expect_rd(CSR_MINSTRET, "instret_3", 32'h3);
        drive(2'b01, CSR_MCOUNTINHIBIT, 32'h4);
        step();
        instret_i = 1'b1;
        step();
        expect_rd(CSR_MINSTRET,  "instret_frozen", 32'h3);
        expect_rd(CSR_MINSTRETH, "instreth",       32'h0);
        expect_rd(CSR_MCYCLE,    "cyc_resumed",    32'h2);

        // mie WARL and interrupt pending latency
        drive(2'b01, CSR_MIE, 32'hFFFF_FFFF);
        step();
        expect_rd(CSR_MIE, "mie_warl", 32'h0000_0888);
        drive(2'b01, CSR_MIE, 32'h80);
        step();
        drive(2'b10, CSR_MSTATUS, 32'h08);
        step();
        expect_rd(CSR_MSTATUS, "mst_mie_set", 32'h0000_1888);
        irq_timer_i = 1'b1;
        sb_push("irqp_c0", 32'h0); sb_pop_cmp(32'(irq_pending_o));
        step();
        sb_push("irqp_c1", 32'h0); sb_pop_cmp(32'(irq_pending_o));
        expect_rd(CSR_MIP, "mip_timer", 32'h80);
        step();
        sb_push("irqp_c2", 32'h1); sb_pop_cmp(32'(irq_pending_o));

        // Asynchronous reset mid-operation
        #3 reset = 1'b1;
        #1;
        sb_push("rst_mid_irqp", 32'h0); sb_pop_cmp(32'(irq_pending_o));
        expect_rd(CSR_MSTATUS, "rst_mid_mstatus", 32'h0000_1800);
        expect_rd(CSR_MIE,     "rst_mid_mie",     32'h0);
        expect_rd(CSR_MCYCLE,  "rst_mid_mcycle",  32'h0);
        sb_push("rst_mid_mepc", 32'h0); sb_pop_cmp(mepc_o);
        step();
        reset = 1'b0;
        repeat (3) step();
        sb_push("post_rst_irqp", 32'h0); sb_pop_cmp(32'(irq_pending_o));

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
